// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path (and the transmitter that
// reuses the oversample divider).
//   uart_rx_state_t : receiver FSM state encoding
//   OVERSAMPLE      : samples taken per bit period
//   MID_SAMPLE      : sample index treated as the centre of the start bit
//   uart_div()      : rounded clock divider for a 16x oversample tick
// Optional build macro: UART_RX_PARITY_EN adds the PARITY state (8E1 frames).
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;

  // The PARITY encoding only exists when even parity is compiled in, so the
  // 8N1 build carries no unreachable state.
  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
`ifdef UART_RX_PARITY_EN
    PARITY    = 3'd4,
`endif
    STOP      = 3'd5
  } uart_rx_state_t;

  // Rounded division: adding half the divisor before the integer divide
  // gives round-to-nearest. Clamped to 1 so a silly baud never yields 0.
  function automatic int uart_div(input int clk_hz, input int baud);
    int div;
    div = (clk_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
    return (div < 1) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if
// Byte hand-off between the UART receiver and its consumer.
//   rx_data    : received byte, stable while rx_valid is high
//   rx_valid   : holding register occupied
//   rx_ready   : consumer accepts the byte when rx_valid & rx_ready
//   frame_err  : one-cycle pulse, stop bit sampled low
//   parity_err : one-cycle pulse, even-parity mismatch
//   overrun    : one-cycle pulse, byte dropped because the register was full
// Modports: master = receiver side, slave = consumer side.
// ---------------------------------------------------------------------------
interface uart_rx_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output parity_err,
    output overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  parity_err,
    input  overrun,
    output rx_ready
  );

endinterface

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
// Free-running divider that produces a one-clock tick every DIV clocks.
// Used at 16x the bit rate by the receiver; the transmitter can share it and
// keep its own bit counter.
//   clk    : system clock (rising edge)
//   rst_n  : asynchronous active-low reset, divider restarts at 0
//   tick_o : one-cycle pulse every DIV clocks
// ---------------------------------------------------------------------------
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Wrap back to zero on the last count so the period is exactly DIV clocks.
  always_comb begin
    count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
  end

  // Divider register; it never stops so the tick phase is fixed by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick_o = (count_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// 16x oversampling UART receiver for the UART_RXD pin. Deframes 8N1
// characters (8E1 when UART_RX_PARITY_EN is defined) and presents each byte
// through a one-entry valid/ready holding register.
//   CLOCK_50 : system clock, all logic on its rising edge
//   RESET_N  : asynchronous active-low reset
//   UART_RXD : raw serial line, asynchronous, idles high
//   rx       : uart_rx_if.master -- rx_data/rx_valid/rx_ready hand-off plus
//              frame_err, parity_err and overrun one-cycle pulses
// Optional build macro: UART_RX_PARITY_EN (even parity bit after the data;
// without it parity_err is tied low).
// ---------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  input  logic UART_RXD,
  uart_rx_if.master rx
);

  localparam int DIV = uart_div(CLK_HZ, BAUD);

  logic           sync1_q;
  logic           sync2_q;
  logic           tick;
  uart_rx_state_t state_q;
  logic [3:0]     sampleCnt_q;
  logic [3:0]     sampleCnt_d;
  logic [2:0]     bitCnt_q;
  logic [7:0]     shift_q;
  logic [7:0]     data_q;
  logic           valid_q;
  logic           frameErr_q;
  logic           overrun_q;
`ifdef UART_RX_PARITY_EN
  logic           parErr_q;
  logic           parityErr_q;
`endif

  // Two-flop synchronizer. Both stages reset high so a reset never looks
  // like a start edge.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= UART_RXD;
      sync2_q <= sync1_q;
    end
  end

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk    (CLOCK_50),
    .rst_n  (RESET_N),
    .tick_o (tick)
  );

  // The sample counter is 4 bits, so the incremented value wrapping to zero
  // marks "16 samples since the last mid-bit point" (and, in WAIT_IDLE,
  // "16 consecutive high samples").
  always_comb begin
    sampleCnt_d = sampleCnt_q + 4'd1;
  end

  // Receiver FSM with registered outputs. Error pulses default low every
  // clock so they last exactly one cycle. Consumer acceptance clears
  // rx_valid first; a delivery in the same clock then overrides it, which is
  // how accept-and-reload keeps rx_valid high with no gap. Bits are shifted
  // in at bit 7 so the first (LSB) bit ends up in bit 0 after eight shifts.
  // A low stop bit goes to WAIT_IDLE so the rest of a corrupt frame (or a
  // break) cannot be mistaken for a new start bit.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= WAIT_IDLE;
      sampleCnt_q <= 4'd0;
      bitCnt_q    <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frameErr_q  <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parErr_q    <= 1'b0;
      parityErr_q <= 1'b0;
`endif
    end else begin
      frameErr_q <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityErr_q <= 1'b0;
`endif
      if (valid_q && rx.rx_ready) begin
        valid_q <= 1'b0;
      end
      if (tick) begin
        case (state_q)
          WAIT_IDLE: begin
            if (!sync2_q) begin
              sampleCnt_q <= 4'd0;
            end else if (sampleCnt_d == 4'd0) begin
              sampleCnt_q <= 4'd0;
              state_q     <= IDLE;
            end else begin
              sampleCnt_q <= sampleCnt_d;
            end
          end
          IDLE: begin
            if (!sync2_q) begin
              sampleCnt_q <= 4'd0;
              state_q     <= START;
            end
          end
          START: begin
            if (sampleCnt_d == 4'(MID_SAMPLE)) begin
              sampleCnt_q <= 4'd0;
              if (sync2_q) begin
                state_q <= IDLE;
              end else begin
                bitCnt_q <= 3'd0;
                state_q  <= DATA;
              end
            end else begin
              sampleCnt_q <= sampleCnt_d;
            end
          end
          DATA: begin
            sampleCnt_q <= sampleCnt_d;
            if (sampleCnt_d == 4'd0) begin
              shift_q  <= {sync2_q, shift_q[7:1]};
              bitCnt_q <= bitCnt_q + 3'd1;
              if (bitCnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state_q <= PARITY;
`else
                state_q <= STOP;
`endif
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            sampleCnt_q <= sampleCnt_d;
            if (sampleCnt_d == 4'd0) begin
              parErr_q <= (sync2_q != (^shift_q));
              state_q  <= STOP;
            end
          end
`endif
          STOP: begin
            sampleCnt_q <= sampleCnt_d;
            if (sampleCnt_d == 4'd0) begin
              if (!sync2_q) begin
                frameErr_q  <= 1'b1;
                sampleCnt_q <= 4'd0;
                state_q     <= WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
              end else if (parErr_q) begin
                parityErr_q <= 1'b1;
                state_q     <= IDLE;
`endif
              end else begin
                state_q <= IDLE;
                if (!valid_q || rx.rx_ready) begin
                  data_q  <= shift_q;
                  valid_q <= 1'b1;
                end else begin
                  overrun_q <= 1'b1;
                end
              end
            end
          end
          default: begin
            sampleCnt_q <= 4'd0;
            state_q     <= WAIT_IDLE;
          end
        endcase
      end
    end
  end

  assign rx.rx_data   = data_q;
  assign rx.rx_valid  = valid_q;
  assign rx.frame_err = frameErr_q;
  assign rx.overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign rx.parity_err = parityErr_q;
`else
  assign rx.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx at 50 MHz / 115200 baud. Frames are driven
// bit by bit on UART_RXD; each frame's expected outcome is derived from the
// framing rules and queued, and a monitor pops and compares whenever the DUT
// presents a byte or an error pulse.
// Optional build macro: UART_RX_PARITY_EN (8E1 frames and parity tests).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CLK_HZ   = 50_000_000;
  localparam int BAUD     = 115200;
  // round(50e6 / (115200*16)) = round(27.13) = 27 clocks per sample tick
  localparam int BIT_CLKS = 27 * 16;
`ifdef UART_RX_PARITY_EN
  localparam int  FRAME_BITS = 11;
  localparam bit  PARITY_ON  = 1'b1;
`else
  localparam int  FRAME_BITS = 10;
  localparam bit  PARITY_ON  = 1'b0;
`endif
  localparam int FRAME_CLKS = FRAME_BITS * BIT_CLKS;

  typedef enum logic [1:0] {EV_BYTE, EV_FRAME, EV_PARITY, EV_OVERRUN} ev_kind_t;
  typedef struct packed {
    ev_kind_t   kind;
    logic [7:0] data;
  } ev_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  logic rxd     = 1'b1;
  logic ready   = 1'b0;

  ev_t  expQ[$];
  int   checks = 0;
  int   errors = 0;
  bit   modelFull  = 1'b0;
  bit   autoAccept = 1'b0;

  uart_rx_if rxIf ();
  assign rxIf.rx_ready = ready;

  uart_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) dut (
    .CLOCK_50 (clock),
    .RESET_N  (reset_n),
    .UART_RXD (rxd),
    .rx       (rxIf)
  );

  always #10 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic scoreEvent(input ev_kind_t kind, input logic [7:0] data);
    ev_t exp;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected event: got kind %0d data 0x%0h, expected none",
               kind, data);
    end else begin
      exp = expQ.pop_front();
      checkOutput("event kind", 32'(kind), 32'(exp.kind));
      if (exp.kind == EV_BYTE) begin
        checkOutput("event data", 32'(data), 32'(exp.data));
      end
    end
  endtask

  // Monitor: samples on the falling edge. A byte is newly presented when
  // rx_valid rises, or stays high right after a handshake (accept-and-reload).
  // While a byte is held unaccepted it must stay valid and unchanged.
  logic       prevValid = 1'b0;
  logic       prevReady = 1'b0;
  logic [7:0] prevData  = 8'h00;
  always @(negedge clock) begin
    if (!reset_n) begin
      prevValid = 1'b0;
      prevReady = 1'b0;
    end else begin
      if (prevValid && !prevReady) begin
        checkOutput("rx_valid held", 32'(rxIf.rx_valid), 32'd1);
        checkOutput("rx_data stable", 32'(rxIf.rx_data), 32'(prevData));
      end else if (rxIf.rx_valid) begin
        scoreEvent(EV_BYTE, rxIf.rx_data);
      end
      if (rxIf.frame_err)  scoreEvent(EV_FRAME, 8'h00);
      if (rxIf.parity_err) scoreEvent(EV_PARITY, 8'h00);
      if (rxIf.overrun)    scoreEvent(EV_OVERRUN, 8'h00);
      prevValid = rxIf.rx_valid;
      prevReady = ready;
      prevData  = rxIf.rx_data;
    end
  end

  task automatic driveBit(input logic b);
    rxd = b;
    repeat (BIT_CLKS) @(posedge clock);
    #1;
  endtask

  task automatic idle(input int nBits);
    rxd = 1'b1;
    repeat (nBits * BIT_CLKS) @(posedge clock);
    #1;
  endtask

  // Reference model plus frame driver. The outcome follows the framing
  // rules: bad stop wins, then bad parity, then the holding register decides
  // between delivery and overrun.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                               input bit parFlip, input bit acceptAtDelivery,
                               input bit timingCheck);
    if (!stopBit) begin
      expQ.push_back('{EV_FRAME, 8'h00});
    end else if (PARITY_ON && parFlip) begin
      expQ.push_back('{EV_PARITY, 8'h00});
    end else if (autoAccept) begin
      expQ.push_back('{EV_BYTE, data});
    end else if (modelFull && !acceptAtDelivery) begin
      expQ.push_back('{EV_OVERRUN, 8'h00});
    end else begin
      expQ.push_back('{EV_BYTE, data});
      modelFull = 1'b1;
    end
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(data[i]);
`ifdef UART_RX_PARITY_EN
    driveBit((^data) ^ parFlip);
`endif
    if (timingCheck) begin
      // Mid-stop sample lands ~191..219 clocks into the stop bit.
      rxd = stopBit;
      repeat (150) @(posedge clock);
      #1 checkOutput("rx_valid before mid-stop", 32'(rxIf.rx_valid), 32'd0);
      repeat (150) @(posedge clock);
      #1 checkOutput("rx_valid after mid-stop", 32'(rxIf.rx_valid), 32'd1);
      repeat (BIT_CLKS - 300) @(posedge clock);
      #1;
    end else begin
      driveBit(stopBit);
    end
  endtask

  task automatic acceptByte();
    ready = 1'b1;
    @(posedge clock);
    #1 ready = 1'b0;
    modelFull = 1'b0;
    checkOutput("accept drops rx_valid", 32'(rxIf.rx_valid), 32'd0);
  endtask

  initial begin
    #5 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset rx_data", 32'(rxIf.rx_data), 32'h00);
    checkOutput("reset rx_valid", 32'(rxIf.rx_valid), 32'd0);
    checkOutput("reset frame_err", 32'(rxIf.frame_err), 32'd0);
    checkOutput("reset parity_err", 32'(rxIf.parity_err), 32'd0);
    checkOutput("reset overrun", 32'(rxIf.overrun), 32'd0);
    reset_n = 1'b1;
    idle(2);

    $display("[TB] 0xA5 with rx_ready low");
    applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1);
    checkOutput("0xA5 held data", 32'(rxIf.rx_data), 32'hA5);
    checkOutput("0xA5 held valid", 32'(rxIf.rx_valid), 32'd1);
    acceptByte();

    $display("[TB] 100-clock glitch");
    rxd = 1'b0;
    repeat (100) @(posedge clock);
    #1;
    idle(2);
    checkOutput("glitch: nothing pending", 32'(expQ.size()), 32'd0);

    $display("[TB] framing error then 0x55");
    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    rxd = 1'b0;
    repeat (2 * BIT_CLKS) @(posedge clock);
    #1;
    idle(2);
    checkOutput("frame_err: no byte", 32'(rxIf.rx_valid), 32'd0);
    applyStimulus(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    checkOutput("0x55 data", 32'(rxIf.rx_data), 32'h55);
    acceptByte();

    $display("[TB] overrun");
    applyStimulus(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    checkOutput("overrun keeps old byte", 32'(rxIf.rx_data), 32'h11);
    acceptByte();

    $display("[TB] accept on delivery cycle");
    fork
      begin
        applyStimulus(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h22, 1'b1, 1'b0, 1'b1, 1'b0);
      end
      begin : pulser
        int k;
        k = 0;
        while (!rxIf.rx_valid && k < 2 * FRAME_CLKS) begin
          @(negedge clock);
          k++;
        end
        checkOutput("0x11 presented in time", 32'(rxIf.rx_valid), 32'd1);
        if (rxIf.rx_valid) begin
          // Frames are back to back on an exact bit grid, so 0x22 lands
          // exactly one frame length after 0x11.
          repeat (FRAME_CLKS - 1) @(posedge clock);
          #1 ready = 1'b1;
          @(posedge clock);
          #1 ready = 1'b0;
        end
      end
    join
    idle(1);
    checkOutput("reload data", 32'(rxIf.rx_data), 32'h22);
    checkOutput("reload valid", 32'(rxIf.rx_valid), 32'd1);
    acceptByte();

    $display("[TB] reset during bit 4 of 0x00");
    for (int i = 0; i < 5; i++) driveBit(1'b0);
    rxd = 1'b0;
    repeat (200) @(posedge clock);
    #1 reset_n = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    checkOutput("mid-frame reset rx_data", 32'(rxIf.rx_data), 32'h00);
    checkOutput("mid-frame reset rx_valid", 32'(rxIf.rx_valid), 32'd0);
    checkOutput("mid-frame reset errors",
                32'({rxIf.frame_err, rxIf.parity_err, rxIf.overrun}), 32'd0);
    repeat (300) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (2 * BIT_CLKS - 505) @(posedge clock);
    #1;
    driveBit(1'b0);
    driveBit(1'b0);
`ifdef UART_RX_PARITY_EN
    driveBit(1'b0);
`endif
    driveBit(1'b1);
    modelFull = 1'b0;
    idle(2);
    checkOutput("no byte from frame tail", 32'(rxIf.rx_valid), 32'd0);
    applyStimulus(8'h7E, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    checkOutput("0x7E data", 32'(rxIf.rx_data), 32'h7E);
    acceptByte();

`ifdef UART_RX_PARITY_EN
    $display("[TB] parity");
    applyStimulus(8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);
    checkOutput("parity_err: no byte", 32'(rxIf.rx_valid), 32'd0);
    applyStimulus(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    checkOutput("parity ok data", 32'(rxIf.rx_data), 32'h01);
    acceptByte();
`endif

    $display("[TB] random frames");
    autoAccept = 1'b1;
    ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      logic [7:0] d;
      bit         bad;
      bit         pf;
      d   = 8'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      pf  = ($urandom_range(0, 3) == 0);
      applyStimulus(d, !bad, pf, 1'b0, 1'b0);
      idle(bad ? 2 : int'($urandom_range(0, 1)));
    end
    idle(1);
    ready = 1'b0;
    autoAccept = 1'b0;

    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver for the board's `UART_RXD` pin, the receive counterpart of the transmit path on `UART_TXD`. It oversamples the line 16× per bit, deframes 8N1 characters (optionally 8E1), and presents each byte on a one-entry valid/ready holding register. Framing, parity and overrun errors are reported as one-cycle pulses. The block sits between the top-level pin and the command/ticket logic.

## Interface
- `CLK_HZ`, 50_000_000, frequency of `CLOCK_50`
- `BAUD`, 115200, line bit rate
- `CLOCK_50`  in  1  system clock; all logic is on its rising edge
- `RESET_N`  in  1  reset, asynchronous, active-low
- `UART_RXD`  in  1  raw serial line, asynchronous to `CLOCK_50`, idles high
- `rx_data`  out  8  received byte; stable while `rx_valid`=1
- `rx_valid`  out  1  byte available; held until accepted
- `rx_ready`  in  1  consumer accepts the byte when `rx_valid`&`rx_ready`
- `frame_err`  out  1  one-cycle pulse: stop bit sampled 0
- `parity_err`  out  1  one-cycle pulse: parity mismatch (tied 0 when parity is compiled out)
- `overrun`  out  1  one-cycle pulse: a byte completed while the holding register was full and not being accepted

## Operation
- `UART_RXD` passes through a 2-flop synchronizer, reset to 1.
- Oversample tick: free-running divider, period DIV = round(CLK_HZ/(BAUD·16)), which is 27 at the defaults. A 4-bit sample counter advances on each tick.
- FSM states: WAIT_IDLE, IDLE, START, DATA, PARITY, STOP.
  - WAIT_IDLE: entered at reset and after a frame error. Moves to IDLE after 16 consecutive high samples. Any low sample restarts the count.
  - IDLE: a low sample moves to START and clears the sample counter.
  - START: at sample 7 (mid-bit), line still low → DATA. Line high → IDLE, treated as a glitch.
  - DATA: every 16 samples from mid-start, shift the line into bit 7 of a shift register (LSB first). After 8 bits → PARITY if compiled in, otherwise → STOP.
  - PARITY: sample mid-bit and compare against the even parity of the data.
  - STOP: sample mid-bit.
    - Sample 1, no parity error → deliver the byte, then → IDLE.
    - Sample 0 → pulse `frame_err`, discard the byte, → WAIT_IDLE.
    - Parity error with a good stop → pulse `parity_err`, discard the byte, → IDLE.
- Holding register behaviour when a byte is delivered:
  - Register empty, or being accepted in the same cycle: load `rx_data`, `rx_valid`=1, no overrun.
  - Register full and `rx_ready`=0: keep the old byte, drop the new one, pulse `overrun`.
- Acceptance (`rx_valid`&`rx_ready`) with no simultaneous delivery: `rx_valid`→0 on the next cycle. `rx_data` holds its last value.
- Reset values:
  - `rx_data`=0x00; `rx_valid`, `frame_err`, `parity_err`, `overrun`=0.
  - FSM=WAIT_IDLE; divider and counters at 0.
- Reset mid-frame abandons the frame. WAIT_IDLE guarantees the remaining bits of that frame produce no spurious byte.

## Timing
- Bit period = 16·DIV clocks, 432 at the defaults.
- Start-edge detection: 2 sync cycles plus up to DIV cycles of tick phase. Resulting sample-point error is ≤1/16 bit.
- `rx_valid` rises 1 clock after the tick that samples mid-stop.
- Error pulses are exactly 1 clock wide, on the same cycle `rx_valid` would have risen.
- Back-to-back frames (stop bit directly followed by a start bit) are received without loss. After STOP the FSM is back in IDLE within half a bit.
- Baud mismatch tolerance is ±3% at 8N1.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: frames are 8E1, the PARITY state exists and `parity_err` is live.
  - Undefined: frames are 8N1, the PARITY state is not generated, STOP follows DATA directly, and `parity_err` is constant 0.

## Structure
- Package `uart_pkg`:
  - `uart_rx_state_t` enum.
  - `OVERSAMPLE`=16, `MID_SAMPLE`=7.
  - Function `uart_div(clk_hz, baud)`, shared with the transmitter.
- Sub-module `uart_baud_tick`: parameterized divider producing the 1-cycle oversample tick. It is reusable by the transmitter at 16× with its own bit counter.

## Test plan
- 0xA5 as 8N1 at 115200, `rx_ready`=0 → `rx_data`=0xA5 and `rx_valid`=1 at mid-stop +1 clock, held. Raise `rx_ready` → `rx_valid`=0 next clock.
- 100-clock low glitch on an idle line → FSM returns to IDLE; no `rx_valid` and no error pulses.
- 0x3C with stop bit forced 0, line held low 2 bit times then released → single `frame_err` pulse, no `rx_valid`. A following 0x55 is received correctly.
- 0x11 then 0x22 back-to-back with `rx_ready`=0 → `rx_data` stays 0x11 and `overrun` pulses once at the end of 0x22. Repeat with `rx_ready` pulsed on 0x22's delivery cycle → `rx_data`=0x22, `rx_valid` stays 1, no overrun.
- Assert `RESET_N`=0 during bit 4 of 0x00, release mid-frame → all outputs 0 and no byte from the tail of that frame. A following 0x7E is received.
- With `UART_RX_PARITY_EN`, send 0x01 with parity bit 0 → `parity_err` pulse, no `rx_valid`. 0x01 with parity bit 1 → `rx_data`=0x01.
